// File: rtl/steer_en_fsm_pkg.sv
// Shared types and constants for the rider-detect / steering-enable stage.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;

  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_FULL = 26;

endpackage

// File: rtl/steer_en_fsm_if.sv
// Load-cell sample strobe in, steering enable / rider-off status out.
interface steer_en_fsm_if;

  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  modport master (
    output ld_vld,
    output lft_ld,
    output rght_ld,
    input  en_steer,
    input  rider_off
  );

  modport slave (
    input  ld_vld,
    input  lft_ld,
    input  rght_ld,
    output en_steer,
    output rider_off
  );

endinterface

// File: rtl/steer_en_fsm_settle_tmr.sv
// Settle timer: free-running up-counter, cleared on demand, saturating at all-ones.
module settle_tmr #(
  parameter int W = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic full
);

  logic [W-1:0] r_cnt;

  // Saturate rather than wrap so a long idle wait never loses the settled flag
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (!(&r_cnt)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign full = &r_cnt;

endmodule

// File: rtl/steer_en_fsm.sv
// Rider presence / balance / settle detection producing en_steer and rider_off.
module steer_en_fsm
  import steer_pkg::*;
#(
  parameter logic        FAST_SIM     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
  input logic           clk,
  input logic           rst,
  steer_en_fsm_if.slave bus
);

  localparam int          TMR_W   = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;
  localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  logic [11:0] r_lft_p0;
  logic [11:0] r_rght_p0;
  state_t      r_state_p1;
  state_t      w_nxt_state;
  logic        r_en_steer_p2;
  logic        r_rider_off_p2;
  logic        w_en_dec;
  logic        w_off_dec;
  logic        w_clr_tmr;
  logic        w_tmr_full;

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic        w_sum_gt_min;
  logic        w_sum_lt_min;
  logic        w_diff_gt_1_4;
  logic        w_diff_gt_15_16;

  // ---- p0: input sample registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lft_p0  <= '0;
      r_rght_p0 <= '0;
    end else if (bus.ld_vld) begin
      r_lft_p0  <= bus.lft_ld;
      r_rght_p0 <= bus.rght_ld;
    end
  end

  assign w_sum  = {1'b0, r_lft_p0} + {1'b0, r_rght_p0};
  assign w_diff = (r_lft_p0 >= r_rght_p0) ? (r_lft_p0 - r_rght_p0)
                                          : (r_rght_p0 - r_lft_p0);

  assign w_sum_gt_min    = w_sum > ON_THR;
  assign w_sum_lt_min    = w_sum < OFF_THR;
  assign w_diff_gt_1_4   = {1'b0, w_diff} > (w_sum >> 2);
  assign w_diff_gt_15_16 = {1'b0, w_diff} > (w_sum - (w_sum >> 4));

  settle_tmr #(
    .W (TMR_W)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr_tmr),
    .full (w_tmr_full)
  );

  // ---- p1: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_p1 <= IDLE;
    end else begin
      r_state_p1 <= w_nxt_state;
    end
  end

  // Rider-off beats imbalance, which beats the timer
  always_comb begin
    w_nxt_state = r_state_p1;
    w_clr_tmr   = 1'b0;
    case (r_state_p1)
      IDLE: begin
        if (w_sum_gt_min) begin
          w_nxt_state = WAIT;
          w_clr_tmr   = 1'b1;
        end
      end
      WAIT: begin
        if (w_sum_lt_min) begin
          w_nxt_state = IDLE;
        end else if (w_diff_gt_1_4) begin
          w_clr_tmr   = 1'b1;
        end else if (w_tmr_full) begin
          w_nxt_state = STEER;
        end
      end
      STEER: begin
        if (w_sum_lt_min) begin
          w_nxt_state = IDLE;
        end else if (w_diff_gt_15_16) begin
          w_nxt_state = WAIT;
          w_clr_tmr   = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_comb begin
    w_en_dec  = 1'b0;
    w_off_dec = 1'b0;
    case (r_state_p1)
      STEER:   w_en_dec  = 1'b1;
      IDLE:    w_off_dec = 1'b1;
      default: ;
    endcase
  end

  // ---- p2: registered Moore outputs, one edge behind the state
  always_ff @(posedge clk) begin
    r_en_steer_p2  <= w_en_dec;
    r_rider_off_p2 <= w_off_dec;
  end

  assign bus.en_steer  = r_en_steer_p2;
  assign bus.rider_off = r_rider_off_p2;

endmodule

// File: tb/tb_steer_en_fsm.sv
// Bench for steer_en_fsm: per-cycle scoreboard against a behavioural model plus latency checks.
module tb_steer_en_fsm;
  import steer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  steer_en_fsm_if bus ();

  steer_en_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  bit         sb_on = 1'b0;
  logic [1:0] sb_q[$];

  int   m_l   = 0;
  int   m_r   = 0;
  int   m_st  = 3;
  int   m_tmr = 0;
  logic m_en  = 1'bx;
  logic m_off = 1'bx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural reference: thresholds 0x200 on, 0x1C0 off, 15-bit settle count
  task automatic model_step();
    int   sum;
    int   diff;
    int   nst;
    bit   clr;
    logic nen;
    logic noff;
    sum  = m_l + m_r;
    diff = (m_l > m_r) ? (m_l - m_r) : (m_r - m_l);
    nst  = m_st;
    clr  = 1'b0;
    case (m_st)
      0: if (sum > 512) begin nst = 1; clr = 1'b1; end
      1: if (sum < 448) nst = 0;
         else if (diff > sum / 4) clr = 1'b1;
         else if (m_tmr == 32767) nst = 2;
      2: if (sum < 448) nst = 0;
         else if (diff > sum - sum / 16) begin nst = 1; clr = 1'b1; end
      default: ;
    endcase
    nen  = (m_st == 2);
    noff = (m_st == 0);
    if (rst) begin
      m_l = 0; m_r = 0; m_st = 0; m_tmr = 0;
    end else begin
      if (bus.ld_vld) begin
        m_l = int'(bus.lft_ld);
        m_r = int'(bus.rght_ld);
      end
      m_st  = nst;
      m_tmr = clr ? 0 : ((m_tmr == 32767) ? 32767 : m_tmr + 1);
    end
    m_en  = nen;
    m_off = noff;
  endtask

  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    model_step();
    if (sb_on) sb_q.push_back({m_en, m_off});
    #1;
    if (sb_on && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("en_cyc", 32'(bus.en_steer), 32'(e[1]));
      chk("off_cyc", 32'(bus.rider_off), 32'(e[0]));
    end
  endtask

  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    bus.ld_vld  = 1'b1;
    bus.lft_ld  = l;
    bus.rght_ld = r;
    tick();
    bus.ld_vld  = 1'b0;
  endtask

  // Ticks until the chosen output reaches val; n exceeds limit-1 only on timeout
  task automatic wait_out(input bit sel_en, input logic val, input int limit, output int n);
    n = 0;
    while (((sel_en ? bus.en_steer : bus.rider_off) !== val) && (n < limit)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    bus.ld_vld  = 1'b0;
    bus.lft_ld  = '0;
    bus.rght_ld = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_en", 32'(bus.en_steer), 32'd0);
    chk("rst_off", 32'(bus.rider_off), 32'd1);
    chk("rst_state", 32'(dut.r_state_p1), 32'(IDLE));
    rst   = 1'b0;
    sb_on = 1'b1;
    repeat (5) tick();
    chk("idle_hold_off", 32'(bus.rider_off), 32'd1);

    // Mount balanced and settle
    strobe(12'h180, 12'h180);
    wait_out(1'b0, 1'b0, 10, n);
    chk("mount_lat", 32'(n), 32'd2);
    wait_out(1'b1, 1'b1, 40000, n);
    chk("settle_lat", 32'(n), 32'd32768);

    // Exactly at the off threshold: hold STEER; timer stays saturated
    strobe(12'h0E0, 12'h0E0);
    repeat (8) tick();
    chk("hyst_hold_en", 32'(bus.en_steer), 32'd1);
    chk("tmr_sat", 32'(dut.u_tmr.r_cnt), 32'h7FFF);

    // Hard lean drops back to WAIT
    strobe(12'h3F0, 12'h008);
    wait_out(1'b1, 1'b0, 10, n);
    chk("lean_lat", 32'(n), 32'd2);
    chk("lean_off", 32'(bus.rider_off), 32'd0);
    chk("lean_state", 32'(dut.r_state_p1), 32'(WAIT));

    // One below the off threshold: rider gone
    strobe(12'h0E0, 12'h0DF);
    wait_out(1'b0, 1'b1, 10, n);
    chk("stepoff_lat", 32'(n), 32'd2);
    chk("stepoff_en", 32'(bus.en_steer), 32'd0);

    // Remount, imbalance late in the settle window, then rebalance
    strobe(12'h180, 12'h180);
    repeat (20000) tick();
    chk("wait_state", 32'(dut.r_state_p1), 32'(WAIT));
    chk("wait_en", 32'(bus.en_steer), 32'd0);
    strobe(12'h300, 12'h100);
    strobe(12'h180, 12'h180);
    wait_out(1'b1, 1'b1, 40000, n);
    chk("restart_lat", 32'(n), 32'd32769);

    // Reset while steering
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(dut.r_state_p1), 32'(IDLE));
    chk("mrst_lft", 32'(dut.r_lft_p0), 32'd0);
    chk("mrst_rght", 32'(dut.r_rght_p0), 32'd0);
    chk("mrst_tmr", 32'(dut.u_tmr.r_cnt), 32'd0);
    chk("mrst_en_lag", 32'(bus.en_steer), 32'd1);
    rst = 1'b0;
    tick();
    chk("mrst_en", 32'(bus.en_steer), 32'd0);
    chk("mrst_off", 32'(bus.rider_off), 32'd1);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
